pc_out_arbiter: RTL and testbench

//  Packet-atomic weighted round-robin arbiter sharing the PC_out upstream link between NIN serialized word sources.

---
 rtl/pc_out_arbiter.sv | 146 ++++++++++++++
 tb/tb_pc_out_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_out_arbiter.sv
// Packet-atomic weighted round-robin arbiter for the shared PC_out upstream link.
// Optional per-input word/packet counters are built when PC_ARB_STATS_EN is defined.
module pc_out_arbiter #(
   parameter  int unsigned NIN = 2,
   parameter  int unsigned NW  = 32,
   parameter  int unsigned NWT = 4,
   localparam int unsigned SW  = $clog2(NIN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NIN-1:0]     in_v,
   output logic [NIN-1:0]     in_a,
   input  logic [NIN*NW-1:0]  in_d,
   input  logic [NIN-1:0]     in_last,
   input  logic [NIN*NWT-1:0] weight,
   output logic               out_v,
   input  logic               out_a,
   output logic [NW-1:0]      out_d,
   output logic [SW-1:0]      out_src
`ifdef PC_ARB_STATS_EN
   ,
   output logic [NIN*32-1:0]  stat_words,
   output logic [NIN*16-1:0]  stat_pkts,
   input  logic               stat_clr
`endif
);

   typedef enum logic {IDLE, LOCK} state_e;

   state_e           state_q;
   logic [SW-1:0]    ptr_q;
   logic [SW-1:0]    grant_q;
   logic [NWT-1:0]   credit_q;
   logic             out_v_q;
   logic [NW-1:0]    out_d_q;
   logic [SW-1:0]    out_src_q;

   logic [NW-1:0]    d_arr [NIN];
   logic [NWT-1:0]   w_arr [NIN];
   logic             found;
   logic [SW-1:0]    win;
   logic             free;
   logic             accept;
   logic             others;
   logic [SW-1:0]    ptr_d;

   for (genvar i = 0; i < NIN; i++) begin : g_unpack
      assign d_arr[i] = in_d[i*NW +: NW];
      assign w_arr[i] = weight[i*NWT +: NWT];
   end

   assign out_v   = out_v_q;
   assign out_d   = out_d_q;
   assign out_src = out_src_q;

   assign free   = !out_v_q || out_a;
   assign accept = |(in_v & in_a);
   assign others = |(in_v & ~(NIN'(1) << grant_q));
   assign ptr_d  = (grant_q == SW'(NIN-1)) ? '0 : grant_q + SW'(1);

   // Round-robin search starting at ptr_q; first requester wins.
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      win   = '0;
      for (int unsigned k = 0; k < NIN; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= NIN) idx = idx - NIN;
         if (!found && in_v[SW'(idx)]) begin
            found = 1'b1;
            win   = SW'(idx);
         end
      end
   end

   always_comb begin
      in_a = '0;
      if (state_q == LOCK && free) in_a[grant_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         credit_q  <= '0;
         out_v_q   <= 1'b0;
         out_d_q   <= '0;
         out_src_q <= '0;
      end else begin
         if (accept) begin
            out_v_q   <= 1'b1;
            out_d_q   <= d_arr[grant_q];
            out_src_q <= grant_q;
         end else if (out_a) begin
            out_v_q   <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (found) begin
                  grant_q  <= win;
                  credit_q <= w_arr[win];
                  state_q  <= LOCK;
               end
            end
            LOCK: begin
               // Turn ends only on a packet boundary; a lone requester keeps its credit.
               if (accept && in_last[grant_q]) begin
                  if (credit_q == '0) begin
                     ptr_q   <= ptr_d;
                     state_q <= IDLE;
                  end else if (others) begin
                     credit_q <= credit_q - NWT'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef PC_ARB_STATS_EN
   for (genvar i = 0; i < NIN; i++) begin : g_stats
      logic [31:0] words_q;
      logic [15:0] pkts_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            words_q <= '0;
            pkts_q  <= '0;
         end else if (stat_clr) begin
            words_q <= '0;
            pkts_q  <= '0;
         end else if (in_v[i] && in_a[i]) begin
            words_q <= words_q + 32'd1;
            if (in_last[i] && pkts_q != 16'hFFFF) pkts_q <= pkts_q + 16'd1;
         end
      end

      assign stat_words[i*32 +: 32] = words_q;
      assign stat_pkts[i*16 +: 16]  = pkts_q;
   end
`endif

endmodule

// File: tb/tb_pc_out_arbiter.sv
// Scoreboard bench for pc_out_arbiter: packet-level WRR model feeds an expected-word queue,
// an independent monitor pops and compares each word leaving the arbiter.
module tb_pc_out_arbiter;
   localparam int unsigned NIN = 3;
   localparam int unsigned NW  = 32;
   localparam int unsigned NWT = 4;
   localparam int unsigned SW  = $clog2(NIN);

   logic               clk = 1'b0;
   logic               reset;
   logic [NIN-1:0]     in_v;
   logic [NIN-1:0]     in_a;
   logic [NIN*NW-1:0]  in_d;
   logic [NIN-1:0]     in_last;
   logic [NIN*NWT-1:0] weight;
   logic               out_v;
   logic               out_a;
   logic [NW-1:0]      out_d;
   logic [SW-1:0]      out_src;
`ifdef PC_ARB_STATS_EN
   logic [NIN*32-1:0]  stat_words;
   logic [NIN*16-1:0]  stat_pkts;
   logic               stat_clr;
`endif

   pc_out_arbiter #(.NIN(NIN), .NW(NW), .NWT(NWT)) dut (
      .clk     (clk),
      .reset   (reset),
      .in_v    (in_v),
      .in_a    (in_a),
      .in_d    (in_d),
      .in_last (in_last),
      .weight  (weight),
      .out_v   (out_v),
      .out_a   (out_a),
      .out_d   (out_d),
      .out_src (out_src)
`ifdef PC_ARB_STATS_EN
      ,
      .stat_words (stat_words),
      .stat_pkts  (stat_pkts),
      .stat_clr   (stat_clr)
`endif
   );

   always #5 clk = ~clk;

   typedef logic [NW:0] word_t;   // bit NW marks the last word of a packet
   typedef struct packed {
      logic [SW-1:0] src;
      logic [NW-1:0] d;
   } exp_t;

   word_t srcq [NIN][$];
   exp_t  expq [$];
   exp_t  mon_e;
   bit    mid [NIN];
   int    gap_left [NIN];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: consumes one expected word per output handshake.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset === 1'b1 && expq.size() > 0) begin
            if (out_v && !out_a) chk("stall_in_a", 64'(in_a), 64'd0);
            if (out_v && out_a) begin
               mon_e = expq.pop_front();
               chk("out_d", 64'(out_d), 64'(mon_e.d));
               chk("out_src", 64'(out_src), 64'(mon_e.src));
            end
         end
      end
   end

   task automatic run_phase(input logic [NIN-1:0] act, input int npk, input int oa_pct,
                            input bit gaps, input int wfix[NIN], input bit timing);
      int    w [NIN];
      word_t modelq [NIN][$];
      word_t x;
      int    ptr, cnt, g, turn, nact, len, budget;
      bit    ovh [5];
      bit    done, v;

      for (int s = 0; s < NIN; s++) begin
         w[s] = (wfix[s] < 0) ? int'($urandom_range(0, 3)) : wfix[s];
         weight[s*NWT +: NWT] = NWT'(w[s]);
         mid[s] = 1'b0;
         gap_left[s] = 0;
         if (act[s]) begin
            for (int j = 0; j < npk + 2; j++) begin
               len = timing ? 3 : int'($urandom_range(1, 4));
               for (int k = 0; k < len; k++) begin
                  x = {k == len - 1, 8'(s), 8'(j), 8'(k), 8'($urandom)};
                  srcq[s].push_back(x);
                  modelq[s].push_back(x);
               end
            end
         end
      end

      // Packet-level model: every active source always has a packet pending.
      nact = $countones(act);
      ptr = 0;
      cnt = 0;
      while (cnt < npk) begin
         g = ptr;
         while (!act[g]) g = (g + 1) % NIN;
         turn = (nact > 1) ? w[g] + 1 : npk;
         for (int t = 0; t < turn && cnt < npk; t++) begin
            do begin
               x = modelq[g].pop_front();
               expq.push_back({SW'(g), x[NW-1:0]});
            end while (!x[NW]);
            cnt++;
         end
         ptr = (g + 1) % NIN;
      end

      budget = 200 + npk * 40;
      done = 1'b0;
      for (int it = 0; it < budget && !done; it++) begin
         @(negedge clk);
         if (expq.size() == 0) begin
            done = 1'b1;
         end else begin
            out_a = ($urandom_range(1, 100) <= oa_pct);
            for (int s = 0; s < NIN; s++) begin
               if (srcq[s].size() == 0) v = 1'b0;
               else if (gap_left[s] > 0) begin v = 1'b0; gap_left[s]--; end
               else if (gaps && mid[s] && $urandom_range(0, 3) == 0) begin
                  v = 1'b0;
                  gap_left[s] = int'($urandom_range(0, 3));
               end else v = 1'b1;
               in_v[s] = v;
               if (srcq[s].size() > 0) begin
                  x = srcq[s][0];
                  in_d[s*NW +: NW] = x[NW-1:0];
                  in_last[s] = x[NW];
               end
            end
            #1;
            if (timing && it < 5) ovh[it] = out_v;
            for (int s = 0; s < NIN; s++) begin
               if (in_v[s] && in_a[s]) begin
                  x = srcq[s].pop_front();
                  mid[s] = !x[NW];
               end
            end
         end
      end
      if (!done) chk("phase_timeout", 64'(expq.size()), 64'd0);

      if (timing && done) begin
         chk("lat_bubble0", 64'(ovh[0]), 64'd0);
         chk("lat_bubble1", 64'(ovh[1]), 64'd0);
         chk("lat_word0", 64'(ovh[2]), 64'd1);
         chk("lat_word1", 64'(ovh[3]), 64'd1);
         chk("lat_word2", 64'(ovh[4]), 64'd1);
      end

      // Asynchronous reset, usually landing mid-packet while sources still stream.
      reset = 1'b0;
      #1;
      chk("rst_out_v", 64'(out_v), 64'd0);
      chk("rst_in_a", 64'(in_a), 64'd0);
      chk("rst_out_d", 64'(out_d), 64'd0);
      for (int s = 0; s < NIN; s++) srcq[s].delete();
      expq.delete();
      in_v = '0;
      out_a = 1'b0;
      repeat (2) @(negedge clk);
`ifdef PC_ARB_STATS_EN
      chk("rst_stat_words", 64'(|stat_words), 64'd0);
      chk("rst_stat_pkts", 64'(|stat_pkts), 64'd0);
`endif
      reset = 1'b1;
   endtask

   initial begin
      reset   = 1'b0;
      in_v    = '0;
      in_d    = '0;
      in_last = '0;
      weight  = '0;
      out_a   = 1'b0;
`ifdef PC_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      chk("reset_out_v", 64'(out_v), 64'd0);
      chk("reset_out_d", 64'(out_d), 64'd0);
      chk("reset_out_src", 64'(out_src), 64'd0);
      chk("reset_in_a", 64'(in_a), 64'd0);
      reset = 1'b1;

      run_phase(3'b001, 1, 100, 1'b0, '{0, 0, 0}, 1'b1);     // single 3-word packet
      run_phase(3'b011, 12, 100, 1'b0, '{0, 0, 0}, 1'b0);    // equal weights alternate
      run_phase(3'b011, 16, 100, 1'b0, '{2, 0, 0}, 1'b0);    // 3:1 weighting
      run_phase(3'b011, 12, 40, 1'b0, '{-1, -1, -1}, 1'b0);  // heavy backpressure
      run_phase(3'b011, 12, 80, 1'b1, '{-1, -1, -1}, 1'b0);  // upstream gaps
      run_phase(3'b111, 15, 100, 1'b0, '{1, 0, 3}, 1'b0);    // three-way wrap
      run_phase(3'b100, 6, 70, 1'b1, '{2, 0, 2}, 1'b0);      // lone requester with credit
      for (int p = 0; p < 10; p++) begin
         logic [NIN-1:0] m;
         m = NIN'($urandom_range(1, (1 << NIN) - 1));
         run_phase(m, 14, int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)),
                   '{-1, -1, -1}, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
